// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter: round-robin share of the bullet slot pool between two players, with per-player frame cooldown and live-bullet cap.
// Optional shot counters for the debug display are built when BULLET_ARB_STATS_EN is defined.
module bullet_slot_arbiter #(
  parameter int NUM_SLOTS       = 16,
  parameter int SLOT_W          = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int MAX_PER_PLAYER  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic                 clear,
  input  logic [1:0]           fire_req,
  input  logic [NUM_SLOTS-1:0] release_mask,
  output logic [1:0]           fire_ack,
  output logic                 spawn_valid,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic                 spawn_owner,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic [NUM_SLOTS-1:0] owner_mask,
  output logic [SLOT_W:0]      count_p1,
  output logic [SLOT_W:0]      count_p2,
  output logic                 pool_full
`ifdef BULLET_ARB_STATS_EN
  ,
  output logic [15:0]          shots_p1,
  output logic [15:0]          shots_p2
`endif
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [SLOT_W:0] MAX_C = (SLOT_W + 1)'(MAX_PER_PLAYER);
  typedef enum logic [1:0] {IDLE, ALLOC, ISSUE} state_t;
  state_t state;
  logic winner, last_grant, pick, has_free;
  logic [1:0] elig;
  logic [1:0][CW-1:0] cd;
  logic [SLOT_W-1:0] free_idx;
  logic [SLOT_W:0] c1, c2;
  always_comb begin
    c1 = '0;
    c2 = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      c1 += (SLOT_W + 1)'(active_mask[i] & ~owner_mask[i]);
      c2 += (SLOT_W + 1)'(active_mask[i] & owner_mask[i]);
    end
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (!active_mask[i]) free_idx = SLOT_W'(i);
  end
  assign has_free = ~&active_mask;
  assign elig[0] = fire_req[0] & (cd[0] == '0) & (count_p1 < MAX_C) & ~pool_full;
  assign elig[1] = fire_req[1] & (cd[1] == '0) & (count_p2 < MAX_C) & ~pool_full;
  // On a tie the player that did not win last time goes first.
  assign pick = (&elig) ? ~last_grant : elig[1];
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      winner      <= 1'b0;
      last_grant  <= 1'b1;
      cd          <= '0;
      fire_ack    <= '0;
      spawn_valid <= 1'b0;
      spawn_slot  <= '0;
      spawn_owner <= 1'b0;
      active_mask <= '0;
      owner_mask  <= '0;
      count_p1    <= '0;
      count_p2    <= '0;
      pool_full   <= 1'b0;
    end else begin
      fire_ack    <= '0;
      spawn_valid <= 1'b0;
      count_p1    <= c1;
      count_p2    <= c2;
      pool_full   <= &active_mask;
      active_mask <= active_mask & ~release_mask;
      for (int p = 0; p < 2; p++)
        if (frame_tick && cd[p] != '0) cd[p] <= cd[p] - 1'b1;
      if (clear) begin
        active_mask <= '0;
        owner_mask  <= '0;
        cd          <= '0;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: if (|elig) begin
            winner <= pick;
            state  <= ALLOC;
          end
          ALLOC: begin
            state <= has_free ? ISSUE : IDLE;
            // Issue side effects land together with the registered spawn pulse so the
            // next IDLE already sees this bullet in the counts and pool_full.
            if (has_free) begin
              spawn_valid           <= 1'b1;
              spawn_slot            <= free_idx;
              spawn_owner           <= winner;
              fire_ack              <= winner ? 2'b10 : 2'b01;
              active_mask[free_idx] <= 1'b1;
              owner_mask[free_idx]  <= winner;
              last_grant            <= winner;
              cd[winner]            <= CW'(COOLDOWN_FRAMES);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef BULLET_ARB_STATS_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shots_p1 <= '0;
      shots_p2 <= '0;
    end else if (clear) begin
      shots_p1 <= '0;
      shots_p2 <= '0;
    end else begin
      if (fire_ack[0] && shots_p1 != 16'hFFFF) shots_p1 <= shots_p1 + 16'd1;
      if (fire_ack[1] && shots_p2 != 16'hFFFF) shots_p2 <= shots_p2 + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// tb_bullet_slot_arbiter: directed scenarios plus random traffic against a slot-pool reference model.
module tb_bullet_slot_arbiter;
  localparam int MAXP = 8;
  localparam int CDF  = 8;
  logic Clk = 1'b0, Reset_n = 1'b0, frame_tick = 1'b0, clear = 1'b0;
  logic [1:0] fire_req = '0;
  logic [15:0] release_mask = '0;
  logic [1:0] fire_ack;
  logic spawn_valid, spawn_owner, pool_full;
  logic [3:0] spawn_slot;
  logic [15:0] active_mask, owner_mask;
  logic [4:0] count_p1, count_p2;
`ifdef BULLET_ARB_STATS_EN
  logic [15:0] shots_p1, shots_p2;
  int m_shots[2];
`endif
  bullet_slot_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .clear(clear),
    .fire_req(fire_req), .release_mask(release_mask), .fire_ack(fire_ack),
    .spawn_valid(spawn_valid), .spawn_slot(spawn_slot), .spawn_owner(spawn_owner),
    .active_mask(active_mask), .owner_mask(owner_mask), .count_p1(count_p1),
    .count_p2(count_p2), .pool_full(pool_full)
`ifdef BULLET_ARB_STATS_EN
    , .shots_p1(shots_p1), .shots_p2(shots_p2)
`endif
  );
  always #5 Clk = ~Clk;
  int checks = 0, passed = 0, fails = 0;
  // Reference model: slot ownership table, cooldown frames left, and a grant pipeline
  // position (0 = free to arbitrate, 1 = winner chosen, 2 = grant on the outputs).
  bit m_act[16], m_own[16];
  int m_cd[2], m_cnt[2];
  bit m_full, m_last, m_win;
  int m_pipe;
  bit e_sv, e_owner;
  int e_slot;
  logic [1:0] e_ack;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_init();
    for (int i = 0; i < 16; i++) begin
      m_act[i] = 0;
      m_own[i] = 0;
    end
    m_cd = '{0, 0};
    m_cnt = '{0, 0};
    m_full = 0;
    m_last = 1;
    m_win = 0;
    m_pipe = 0;
    e_sv = 0;
    e_ack = '0;
    e_slot = 0;
    e_owner = 0;
`ifdef BULLET_ARB_STATS_EN
    m_shots = '{0, 0};
`endif
  endtask
  task automatic check_outputs();
    logic [15:0] ea, eo;
    for (int i = 0; i < 16; i++) begin
      ea[i] = m_act[i];
      eo[i] = m_own[i];
    end
    chk("spawn_valid", 32'(spawn_valid), 32'(e_sv));
    chk("fire_ack", 32'(fire_ack), 32'(e_ack));
    chk("active_mask", 32'(active_mask), 32'(ea));
    chk("owner_mask", 32'(owner_mask), 32'(eo));
    chk("count_p1", 32'(count_p1), m_cnt[0]);
    chk("count_p2", 32'(count_p2), m_cnt[1]);
    chk("pool_full", 32'(pool_full), 32'(m_full));
    if (e_sv) begin
      chk("spawn_slot", 32'(spawn_slot), e_slot);
      chk("spawn_owner", 32'(spawn_owner), 32'(e_owner));
    end
`ifdef BULLET_ARB_STATS_EN
    chk("shots_p1", 32'(shots_p1), m_shots[0]);
    chk("shots_p2", 32'(shots_p2), m_shots[1]);
`endif
  endtask
  task automatic do_reset();
    Reset_n = 0;
    fire_req = '0;
    frame_tick = 0;
    clear = 0;
    release_mask = '0;
    model_init();
    @(posedge Clk);
    #1;
    check_outputs();
    Reset_n = 1;
  endtask
  task automatic step(input logic [1:0] fr, input logic ft, input logic clr, input logic [15:0] rel);
    bit act_old[16];
    int cd_old[2], nc[2], fs;
    bit nfull;
    logic [1:0] el;
    fire_req = fr;
    frame_tick = ft;
    clear = clr;
    release_mask = rel;
    @(posedge Clk);
    act_old = m_act;
    cd_old = m_cd;
    nc = '{0, 0};
    nfull = 1;
    for (int i = 0; i < 16; i++)
      if (m_act[i]) nc[m_own[i]]++;
      else nfull = 0;
    for (int p = 0; p < 2; p++) el[p] = fr[p] && cd_old[p] == 0 && m_cnt[p] < MAXP && !m_full;
`ifdef BULLET_ARB_STATS_EN
    for (int p = 0; p < 2; p++)
      if (clr) m_shots[p] = 0;
      else if (e_ack[p] && m_shots[p] < 65535) m_shots[p]++;
`endif
    e_sv = 0;
    e_ack = '0;
    for (int p = 0; p < 2; p++) if (ft && m_cd[p] > 0) m_cd[p]--;
    for (int i = 0; i < 16; i++) if (rel[i]) m_act[i] = 0;
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        m_act[i] = 0;
        m_own[i] = 0;
      end
      m_cd = '{0, 0};
      m_pipe = 0;
    end else if (m_pipe == 0) begin
      if (|el) begin
        m_win = (&el) ? !m_last : el[1];
        m_pipe = 1;
      end
    end else if (m_pipe == 1) begin
      fs = -1;
      for (int i = 15; i >= 0; i--) if (!act_old[i]) fs = i;
      if (fs >= 0) begin
        e_sv = 1;
        e_slot = fs;
        e_owner = m_win;
        e_ack = m_win ? 2'b10 : 2'b01;
        m_act[fs] = 1;
        m_own[fs] = m_win;
        m_last = m_win;
        m_cd[m_win] = CDF;
        m_pipe = 2;
      end else m_pipe = 0;
    end else m_pipe = 0;
    m_cnt = nc;
    m_full = nfull;
    #1;
    check_outputs();
  endtask
  initial begin
    int got;
    logic [15:0] rel;
    // Single player: first grant two cycles after the request, then frame cooldown.
    do_reset();
    step(2'b01, 0, 0, '0);
    step(2'b01, 0, 0, '0);
    chk("t1_ack", 32'(fire_ack), 32'h1);
    chk("t1_slot", 32'(spawn_slot), 32'h0);
    step(2'b01, 0, 0, '0);
    step(2'b01, 0, 0, '0);
    chk("t1_active", 32'(active_mask), 32'h1);
    chk("t1_count", 32'(count_p1), 32'h1);
    for (int i = 0; i < 40; i++) step(2'b01, i % 4 == 3, 0, '0);
    chk("t1_second", 32'(active_mask), 32'h3);
    // Both players: alternate grants.
    do_reset();
    step(2'b11, 0, 0, '0);
    step(2'b11, 0, 0, '0);
    chk("t2_p1_first", 32'(fire_ack), 32'h1);
    for (int i = 0; i < 3; i++) step(2'b11, 0, 0, '0);
    chk("t2_p2_slot1", 32'(spawn_slot), 32'h1);
    chk("t2_p2_ack", 32'(fire_ack), 32'h2);
    for (int i = 0; i < 120; i++) step(2'b11, i % 3 == 0, 0, '0);
    chk("t2_balance", 32'(count_p1 == count_p2 || count_p1 == count_p2 + 5'd1), 32'h1);
    // Fill the pool, then free slot 5.
    do_reset();
    for (int i = 0; i < 200; i++) step(2'b11, 1, 0, '0);
    chk("t3_full", 32'(pool_full), 32'h1);
    chk("t3_mask", 32'(active_mask), 32'hFFFF);
    step(2'b11, 1, 0, 16'h0020);
    got = 99;
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 1, 0, '0);
      if (spawn_valid && got == 99) got = int'(spawn_slot);
    end
    chk("t3_slot5", got, 5);
    // P1 at its cap: only P2 is served until a P1 bullet dies.
    do_reset();
    for (int i = 0; i < 120; i++) step(2'b01, 1, 0, '0);
    chk("t4_cap", 32'(count_p1), 32'h8);
    for (int i = 0; i < 30; i++) step(2'b11, 1, 0, '0);
    chk("t4_p1_held", 32'(count_p1), 32'h8);
    chk("t4_p2_served", 32'(count_p2 != 0), 32'h1);
    step(2'b01, 1, 0, 16'h0001);
    for (int i = 0; i < 12; i++) step(2'b01, 1, 0, '0);
    chk("t4_regrant", 32'(active_mask[0] & ~owner_mask[0]), 32'h1);
    chk("t4_cap_again", 32'(count_p1), 32'h8);
    // Clear during ALLOC suppresses the grant; held request is served afterwards.
    do_reset();
    step(2'b01, 0, 0, '0);
    step(2'b01, 0, 1, '0);
    chk("t5_no_spawn", 32'(spawn_valid), 32'h0);
    chk("t5_cleared", 32'(active_mask), 32'h0);
    step(2'b01, 0, 0, '0);
    step(2'b01, 0, 0, '0);
    chk("t5_spawn", 32'(spawn_valid), 32'h1);
    chk("t5_slot0", 32'(spawn_slot), 32'h0);
    // Asynchronous reset while the grant is on the outputs.
    do_reset();
    step(2'b01, 0, 0, '0);
    step(2'b01, 0, 0, '0);
    chk("t6_issue", 32'(spawn_valid), 32'h1);
    #2 Reset_n = 0;
    #1;
    chk("t6_sv", 32'(spawn_valid), 32'h0);
    chk("t6_ack", 32'(fire_ack), 32'h0);
    chk("t6_active", 32'(active_mask), 32'h0);
    // Random traffic.
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      rel = ($urandom % 3 == 0) ? (16'($urandom) & 16'($urandom) & 16'($urandom)) : 16'h0;
      step(2'($urandom), $urandom % 4 == 0, $urandom % 97 == 0, rel);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
